// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU ops through in one cycle and runs loads/stores over a req/ack bus.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES BUSY cycles without ack.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memi_instr,
    input  logic [15:0] memi_pc,
    input  logic [15:0] memi_result,
    input  logic [3:0]  memi_wreg_addr,
    input  logic [15:0] memi_write_to_mem_data,
    input  logic [1:0]  memi_rwe,
    output logic        memo_stall,
    output logic [15:0] memo_instr,
    output logic [15:0] memo_pc,
    output logic [15:0] memo_result,
    output logic [3:0]  memo_wreg_addr,
    output logic [1:0]  memo_rwe,
    output logic        memo_valid,
    output logic        memo_err,
    mem_stage_if.master mem_bus
);

    localparam logic [1:0]  RWE_LOAD   = 2'b01;
    localparam logic [1:0]  RWE_STORE  = 2'b10;
    localparam logic [15:0] ABORT_DATA = 16'hDEAD;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_next;

    logic [15:0] op_instr;
    logic [15:0] op_pc;
    logic [3:0]  op_wreg_addr;
    logic [1:0]  op_rwe;

    logic is_mem_op;
    logic ack_done;
    logic abort;

    assign is_mem_op  = (memi_rwe == RWE_LOAD) || (memi_rwe == RWE_STORE);
    assign ack_done   = (state == BUSY) && mem_bus.mem_ack;
    assign memo_stall = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    // Abort lands on the edge where the no-ack count would reach TIMEOUT_CYCLES; ack on that edge wins.
    assign abort = (state == BUSY) && !mem_bus.mem_ack &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!mem_bus.mem_ack) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memo_err <= 1'b0;
        end else begin
            memo_err <= abort;
        end
    end
`else
    assign abort    = 1'b0;
    assign memo_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_mem_op) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_done || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memo_instr         <= '0;
            memo_pc            <= '0;
            memo_result        <= '0;
            memo_wreg_addr     <= '0;
            memo_rwe           <= '0;
            memo_valid         <= 1'b0;
            op_instr           <= '0;
            op_pc              <= '0;
            op_wreg_addr       <= '0;
            op_rwe             <= '0;
            mem_bus.mem_req    <= 1'b0;
            mem_bus.mem_we     <= 1'b0;
            mem_bus.mem_addr   <= '0;
            mem_bus.mem_wdata  <= '0;
        end else begin
            memo_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem_op) begin
                        op_instr          <= memi_instr;
                        op_pc             <= memi_pc;
                        op_wreg_addr      <= memi_wreg_addr;
                        op_rwe            <= memi_rwe;
                        mem_bus.mem_addr  <= memi_result;
                        mem_bus.mem_wdata <= memi_write_to_mem_data;
                        mem_bus.mem_we    <= (memi_rwe == RWE_STORE);
                        mem_bus.mem_req   <= 1'b1;
                    end else begin
                        memo_instr     <= memi_instr;
                        memo_pc        <= memi_pc;
                        memo_result    <= memi_result;
                        memo_wreg_addr <= memi_wreg_addr;
                        memo_rwe       <= memi_rwe;
                        memo_valid     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ack_done || abort) begin
                        memo_instr      <= op_instr;
                        memo_pc         <= op_pc;
                        memo_wreg_addr  <= op_wreg_addr;
                        memo_rwe        <= op_rwe;
                        memo_valid      <= 1'b1;
                        mem_bus.mem_req <= 1'b0;
                        mem_bus.mem_we  <= 1'b0;
                        // Stores report their address; loads report bus data, or a marker on abort.
                        if (op_rwe != RWE_LOAD) begin
                            memo_result <= mem_bus.mem_addr;
                        end else if (ack_done) begin
                            memo_result <= mem_bus.mem_rdata;
                        end else begin
                            memo_result <= ABORT_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized ALU/load/store traffic against a sparse memory model.
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] memi_instr = '0;
    logic [15:0] memi_pc = '0;
    logic [15:0] memi_result = '0;
    logic [3:0]  memi_wreg_addr = '0;
    logic [15:0] memi_write_to_mem_data = '0;
    logic [1:0]  memi_rwe = '0;
    logic        memo_stall;
    logic [15:0] memo_instr;
    logic [15:0] memo_pc;
    logic [15:0] memo_result;
    logic [3:0]  memo_wreg_addr;
    logic [1:0]  memo_rwe;
    logic        memo_valid;
    logic        memo_err;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .memi_instr             (memi_instr),
        .memi_pc                (memi_pc),
        .memi_result            (memi_result),
        .memi_wreg_addr         (memi_wreg_addr),
        .memi_write_to_mem_data (memi_write_to_mem_data),
        .memi_rwe               (memi_rwe),
        .memo_stall             (memo_stall),
        .memo_instr             (memo_instr),
        .memo_pc                (memo_pc),
        .memo_result            (memo_result),
        .memo_wreg_addr         (memo_wreg_addr),
        .memo_rwe               (memo_rwe),
        .memo_valid             (memo_valid),
        .memo_err               (memo_err),
        .mem_bus                (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] result;
        logic [3:0]  wreg;
        logic [1:0]  rwe;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        done = 1'b0;
    logic [15:0] mem_model[logic [15:0]];
    logic [15:0] addr_pool[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scramble();
        memi_instr             = 16'($urandom);
        memi_pc                = 16'($urandom);
        memi_result            = 16'($urandom);
        memi_wreg_addr         = 4'($urandom);
        memi_write_to_mem_data = 16'($urandom);
        memi_rwe               = 2'($urandom);
    endtask

    task automatic alu_op(input logic [1:0] rwe, input logic [15:0] res, input logic [3:0] wreg,
                          input logic ack);
        exp_t e;
        scramble();
        memi_rwe       = rwe;
        memi_result    = res;
        memi_wreg_addr = wreg;
        bus.mem_ack    = ack;
        bus.mem_rdata  = 16'($urandom);
        e.instr = memi_instr; e.pc = memi_pc; e.result = res;
        e.wreg = wreg; e.rwe = rwe; e.err = 1'b0;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("alu_req", 16'(bus.mem_req), 16'd0);
        chk("alu_stall", 16'(memo_stall), 16'd0);
    endtask

    task automatic start_mem(input logic is_store, input logic [15:0] addr, input logic [15:0] data);
        scramble();
        memi_rwe               = is_store ? 2'b10 : 2'b01;
        memi_result            = addr;
        memi_write_to_mem_data = data;
        bus.mem_ack            = 1'b0;
    endtask

    task automatic mem_op(input logic is_store, input logic [15:0] addr, input logic [15:0] data,
                          input int unsigned d);
        exp_t        e;
        logic [15:0] rd;
        if (!mem_model.exists(addr)) mem_model[addr] = 16'($urandom);
        rd = mem_model[addr];
        start_mem(is_store, addr, data);
        e.instr = memi_instr; e.pc = memi_pc; e.result = is_store ? addr : rd;
        e.wreg = memi_wreg_addr; e.rwe = memi_rwe; e.err = 1'b0;
        sbq.push_back(e);
        @(posedge clk); #1;
        chk("bus_req", 16'(bus.mem_req), 16'd1);
        chk("bus_we", 16'(bus.mem_we), 16'(is_store));
        chk("bus_addr", bus.mem_addr, addr);
        if (is_store) chk("bus_wdata", bus.mem_wdata, data);
        chk("busy_stall", 16'(memo_stall), 16'd1);
        chk("bubble", 16'(memo_valid), 16'd0);
        scramble();
        for (int unsigned i = 0; i < d; i++) begin
            bus.mem_rdata = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_req", 16'(bus.mem_req), 16'd1);
            chk("hold_addr", bus.mem_addr, addr);
            chk("hold_stall", 16'(memo_stall), 16'd1);
            scramble();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = is_store ? 16'($urandom) : rd;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("done_req", 16'(bus.mem_req), 16'd0);
        chk("done_we", 16'(bus.mem_we), 16'd0);
        chk("done_stall", 16'(memo_stall), 16'd0);
        if (is_store) mem_model[addr] = data;
    endtask

    // Reset asserted between edges; checks happen before the next clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 16'(bus.mem_req), 16'd0);
        chk("rst_valid", 16'(memo_valid), 16'd0);
        chk("rst_stall", 16'(memo_stall), 16'd0);
        chk("rst_result", memo_result, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest expected op.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !done) begin
                if (memo_valid) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL spurious_valid: got result %h with nothing expected at %0t",
                                 memo_result, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_instr", memo_instr, e.instr);
                        chk("out_pc", memo_pc, e.pc);
                        chk("out_result", memo_result, e.result);
                        chk("out_wreg", 16'(memo_wreg_addr), 16'(e.wreg));
                        chk("out_rwe", 16'(memo_rwe), 16'(e.rwe));
                        chk("out_err", 16'(memo_err), 16'(e.err));
                    end
                end else if (memo_err) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL err_without_valid: got err 1 expected 0 at %0t", $time);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            addr_pool[i] = 16'($urandom);
            mem_model[addr_pool[i]] = 16'($urandom);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", memo_result, 16'd0);
        chk("reset_valid", 16'(memo_valid), 16'd0);
        chk("reset_req", 16'(bus.mem_req), 16'd0);
        chk("reset_addr", bus.mem_addr, 16'd0);
        chk("reset_stall", 16'(memo_stall), 16'd0);
        chk("reset_err", 16'(memo_err), 16'd0);
        rst = 1'b0;

        alu_op(2'b00, 16'h0005, 4'd3, 1'b0);
        mem_model[16'h1234] = 16'hBEEF;
        mem_op(1'b0, 16'h1234, 16'h0000, 2);
        mem_op(1'b1, 16'h0040, 16'hA5A5, 0);
        alu_op(2'b00, 16'h0099, 4'd7, 1'b0);
        alu_op(2'b11, 16'h0007, 4'd1, 1'b1);
        mem_op(1'b0, 16'h0040, 16'h0000, 1);

        // Load abandoned by reset: never completes, so nothing expected.
        start_mem(1'b0, 16'h0300, 16'h0000);
        @(posedge clk); #1;
        chk("pre_rst_req", 16'(bus.mem_req), 16'd1);
        @(posedge clk);
        pulse_reset();
        alu_op(2'b00, 16'h1111, 4'd2, 1'b0);

`ifdef MEM_TIMEOUT_EN
        start_mem(1'b0, 16'h0500, 16'h0000);
        e.instr = memi_instr; e.pc = memi_pc; e.result = 16'hDEAD;
        e.wreg = memi_wreg_addr; e.rwe = 2'b01; e.err = 1'b1;
        sbq.push_back(e);
        @(posedge clk); #1;
        scramble();
        for (int unsigned i = 0; i < TMO - 1; i++) begin
            @(posedge clk); #1;
            chk("tmo_wait_req", 16'(bus.mem_req), 16'd1);
        end
        @(posedge clk); #1;
        chk("tmo_req", 16'(bus.mem_req), 16'd0);
        chk("tmo_stall", 16'(memo_stall), 16'd0);
        alu_op(2'b00, 16'h2222, 4'd4, 1'b0);
`else
        start_mem(1'b0, 16'h0500, 16'h0000);
        @(posedge clk); #1;
        scramble();
        repeat (100) @(posedge clk);
        #1;
        chk("noack_req", 16'(bus.mem_req), 16'd1);
        chk("noack_stall", 16'(memo_stall), 16'd1);
        pulse_reset();
        alu_op(2'b00, 16'h2222, 4'd4, 1'b0);
`endif

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: alu_op($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00, 16'($urandom),
                          4'($urandom), 1'($urandom));
                1, 3: mem_op(1'b0, addr_pool[$urandom_range(0, 7)], 16'h0000,
                             $urandom_range(0, 3));
                default: mem_op(1'b1, addr_pool[$urandom_range(0, 7)], 16'($urandom),
                                $urandom_range(0, 3));
            endcase
        end

        @(negedge clk); #1;
        done = 1'b1;
        chk("queue_drained", 16'(sbq.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
